// File: rtl/stream_packet_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_packet_mux - locks onto one granted stream and forwards its packet
// through a registered output stage, pulsing arb_en_o once per packet end.
// Rev 1.0
// ----------------------------------------------------------------------------
module stream_packet_mux #(
   parameter int STREAM_COUNT = 2,
   parameter int T_DATA_WIDTH = 8,
   parameter int T_ID_WIDTH   = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1
) (
   input  logic                                 clk,
   input  logic                                 nrst,
   input  logic [STREAM_COUNT*T_DATA_WIDTH-1:0] s_data_i,
   input  logic [STREAM_COUNT-1:0]              s_valid_i,
   input  logic [STREAM_COUNT-1:0]              s_last_i,
   output logic [STREAM_COUNT-1:0]              s_ready_o,
   output logic [STREAM_COUNT-1:0]              req_o,
   input  logic [STREAM_COUNT-1:0]              grant_i,
   output logic                                 arb_en_o,
   output logic [T_DATA_WIDTH-1:0]              m_data_o,
   output logic [T_ID_WIDTH-1:0]                m_id_o,
   output logic                                 m_last_o,
   output logic                                 m_valid_o,
   input  logic                                 m_ready_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t                  state;
   logic [STREAM_COUNT-1:0] sel_r;
   logic [T_DATA_WIDTH-1:0] data_arr [STREAM_COUNT];
   logic [T_DATA_WIDTH-1:0] sel_data;
   logic [T_ID_WIDTH-1:0]   sel_id;
   logic                    sel_last;
   logic                    out_free;
   logic                    accept;
   logic                    grant_ok;

   genvar k;
   generate
      for (k = 0; k < STREAM_COUNT; k++) begin : g_unpack
         assign data_arr[k] = s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
      end
   endgenerate

   assign req_o = s_valid_i;

   // A multi-hot grant is rejected even if only one of its bits hits a valid stream.
   assign grant_ok  = $onehot(grant_i) && ((grant_i & s_valid_i) != '0);
   assign out_free  = ~m_valid_o | m_ready_i;
   assign s_ready_o = (state == XFER) ? (sel_r & {STREAM_COUNT{out_free}}) : '0;
   assign accept    = |(s_valid_i & s_ready_o);
   assign sel_last  = |(s_last_i & sel_r);

   // sel_r is one-hot, so OR-reduction acts as the data mux and index encoder.
   always_comb begin
      sel_data = '0;
      sel_id   = '0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (sel_r[i]) begin
            sel_data = sel_data | data_arr[i];
            sel_id   = sel_id | T_ID_WIDTH'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= IDLE;
         sel_r     <= '0;
         arb_en_o  <= 1'b0;
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_id_o    <= '0;
         m_last_o  <= 1'b0;
      end else begin
         arb_en_o <= 1'b0;

         if (accept) begin
            m_data_o  <= sel_data;
            m_id_o    <= sel_id;
            m_last_o  <= sel_last;
            m_valid_o <= 1'b1;
         end else if (m_valid_o && m_ready_i) begin
            m_valid_o <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (grant_ok) begin
                  sel_r <= grant_i;
                  state <= XFER;
               end
            end
            XFER: begin
               if (accept && sel_last) begin
                  arb_en_o <= 1'b1;
                  state    <= SETTLE;
               end
            end
            // One dead cycle lets the arbiter consume the enable before re-sampling.
            SETTLE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stream_packet_mux.sv
`default_nettype none
// tb_stream_packet_mux - directed scenarios plus randomized packet traffic
// checked against a packet-order scoreboard.
module tb_stream_packet_mux;
   localparam int N   = 2;
   localparam int W   = 8;
   localparam int IDW = 1;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
      logic           last;
   } beat_t;

   logic           clk = 1'b0;
   logic           nrst;
   logic [N*W-1:0] s_data_i;
   logic [N-1:0]   s_valid_i, s_last_i, s_ready_o, req_o, grant_i;
   logic           arb_en_o, m_last_o, m_valid_o, m_ready_i;
   logic [W-1:0]   m_data_o;
   logic [IDW-1:0] m_id_o;

   int checks = 0;
   int errors = 0;

   logic [13:0] obs, expv;
   logic [3:0]  ctl, expc;
   assign obs = {m_valid_o, m_last_o, m_id_o, m_data_o, arb_en_o, s_ready_o};
   assign ctl = {m_valid_o, arb_en_o, s_ready_o};

   beat_t sq [N][$];
   beat_t expq [$];
   int    cur;
   bit    has_tgt;

   stream_packet_mux #(.STREAM_COUNT(N), .T_DATA_WIDTH(W), .T_ID_WIDTH(IDW)) dut (
      .clk(clk), .nrst(nrst), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
      .s_last_i(s_last_i), .s_ready_o(s_ready_o), .req_o(req_o), .grant_i(grant_i),
      .arb_en_o(arb_en_o), .m_data_o(m_data_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int k, input logic [W-1:0] d, input logic v, input logic l);
      s_data_i[k*W +: W] = d;
      s_valid_i[k]       = v;
      s_last_i[k]        = l;
   endtask

   // Round-robin choice of the next stream with a pending packet; its beats become expected output.
   task automatic pick_next(input int from);
      int j;
      bit stop;
      has_tgt = 1'b0;
      for (int i = 1; i <= N; i++) begin
         j = (from + i) % N;
         if (!has_tgt && sq[j].size() > 0) begin
            has_tgt = 1'b1;
            cur     = j;
            stop    = 1'b0;
            for (int b = 0; b < sq[j].size() && !stop; b++) begin
               expq.push_back(sq[j][b]);
               stop = sq[j][b].last;
            end
         end
      end
   endtask

   task automatic test_reset();
      step();
      s_valid_i = 2'b11;
      grant_i   = 2'b01;
      step();
      @(negedge clk); checks++; expv = '0;
      if (obs !== expv) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, expv); end
      checks++;
      if (req_o !== 2'b11) begin errors++; $display("FAIL reset_req: got %b expected %b", req_o, 2'b11); end
      step();
      nrst = 1'b1; s_valid_i = '0; grant_i = '0;
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL reset_idle: got %b expected %b", ctl, expc); end
      step();
   endtask

   task automatic test_basic();
      put(0, 8'h11, 1'b1, 1'b0); grant_i = 2'b01; m_ready_i = 1'b1;
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL basic_idle: got %b expected %b", ctl, expc); end
      step();
      @(negedge clk); checks++; expc = 4'b0001;
      if (ctl !== expc) begin errors++; $display("FAIL basic_rdy: got %b expected %b", ctl, expc); end
      step(); put(0, 8'h22, 1'b1, 1'b0);
      @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 2'b01};
      if (obs !== expv) begin errors++; $display("FAIL basic_b0: got %b expected %b", obs, expv); end
      step(); put(0, 8'h33, 1'b1, 1'b1);
      @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 2'b01};
      if (obs !== expv) begin errors++; $display("FAIL basic_b1: got %b expected %b", obs, expv); end
      step(); put(0, 8'h00, 1'b0, 1'b0); grant_i = '0;
      @(negedge clk); checks++; expv = {1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 2'b00};
      if (obs !== expv) begin errors++; $display("FAIL basic_b2: got %b expected %b", obs, expv); end
      step();
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL basic_end: got %b expected %b", ctl, expc); end
      step();
   endtask

   task automatic test_two_streams();
      put(1, 8'h71, 1'b1, 1'b0); put(0, 8'h81, 1'b1, 1'b0); grant_i = 2'b10;
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL two_idle: got %b expected %b", ctl, expc); end
      step();
      @(negedge clk); checks++; expc = 4'b0010;
      if (ctl !== expc) begin errors++; $display("FAIL two_rdy1: got %b expected %b", ctl, expc); end
      step(); put(1, 8'h72, 1'b1, 1'b1);
      @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b1, 8'h71, 1'b0, 2'b10};
      if (obs !== expv) begin errors++; $display("FAIL two_s1b0: got %b expected %b", obs, expv); end
      step(); put(1, 8'h00, 1'b0, 1'b0); grant_i = 2'b01;
      @(negedge clk); checks++; expv = {1'b1, 1'b1, 1'b1, 8'h72, 1'b1, 2'b00};
      if (obs !== expv) begin errors++; $display("FAIL two_s1b1: got %b expected %b", obs, expv); end
      step();
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL two_gap: got %b expected %b", ctl, expc); end
      step();
      @(negedge clk); checks++; expc = 4'b0001;
      if (ctl !== expc) begin errors++; $display("FAIL two_rdy0: got %b expected %b", ctl, expc); end
      step(); put(0, 8'h82, 1'b1, 1'b1);
      @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 2'b01};
      if (obs !== expv) begin errors++; $display("FAIL two_s0b0: got %b expected %b", obs, expv); end
      step(); put(0, 8'h00, 1'b0, 1'b0); grant_i = '0;
      @(negedge clk); checks++; expv = {1'b1, 1'b1, 1'b0, 8'h82, 1'b1, 2'b00};
      if (obs !== expv) begin errors++; $display("FAIL two_s0b1: got %b expected %b", obs, expv); end
      step();
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL two_end: got %b expected %b", ctl, expc); end
      step();
   endtask

   task automatic test_backpressure();
      put(0, 8'h40, 1'b1, 1'b0); grant_i = 2'b01; m_ready_i = 1'b1;
      step();
      @(negedge clk); checks++; expc = 4'b0001;
      if (ctl !== expc) begin errors++; $display("FAIL bp_rdy: got %b expected %b", ctl, expc); end
      step(); put(0, 8'h41, 1'b1, 1'b0);
      @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b0, 8'h40, 1'b0, 2'b01};
      if (obs !== expv) begin errors++; $display("FAIL bp_b0: got %b expected %b", obs, expv); end
      step(); put(0, 8'h42, 1'b1, 1'b0); m_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 2'b00};
         if (obs !== expv) begin errors++; $display("FAIL bp_hold%0d: got %b expected %b", i, obs, expv); end
         step();
      end
      m_ready_i = 1'b1;
      @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 2'b01};
      if (obs !== expv) begin errors++; $display("FAIL bp_release: got %b expected %b", obs, expv); end
      step(); put(0, 8'h43, 1'b1, 1'b1);
      @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b0, 8'h42, 1'b0, 2'b01};
      if (obs !== expv) begin errors++; $display("FAIL bp_b2: got %b expected %b", obs, expv); end
      step(); put(0, 8'h00, 1'b0, 1'b0); grant_i = '0;
      @(negedge clk); checks++; expv = {1'b1, 1'b1, 1'b0, 8'h43, 1'b1, 2'b00};
      if (obs !== expv) begin errors++; $display("FAIL bp_b3: got %b expected %b", obs, expv); end
      step();
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL bp_end: got %b expected %b", ctl, expc); end
      step();
   endtask

   task automatic test_single_beat();
      put(1, 8'hA5, 1'b1, 1'b1); grant_i = 2'b10;
      step();
      @(negedge clk); checks++; expc = 4'b0010;
      if (ctl !== expc) begin errors++; $display("FAIL single_rdy: got %b expected %b", ctl, expc); end
      step(); put(1, 8'h5A, 1'b1, 1'b1);
      @(negedge clk); checks++; expv = {1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 2'b00};
      if (obs !== expv) begin errors++; $display("FAIL single_out: got %b expected %b", obs, expv); end
      step();
      @(negedge clk); checks++; expv = {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 2'b00};
      if (obs !== expv) begin errors++; $display("FAIL single_idle: got %b expected %b", obs, expv); end
      step();
      @(negedge clk); checks++; expv = {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 2'b10};
      if (obs !== expv) begin errors++; $display("FAIL single_recap: got %b expected %b", obs, expv); end
      step(); put(1, 8'h00, 1'b0, 1'b0); grant_i = '0;
      @(negedge clk); checks++; expv = {1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 2'b00};
      if (obs !== expv) begin errors++; $display("FAIL single_out2: got %b expected %b", obs, expv); end
      step();
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL single_end: got %b expected %b", ctl, expc); end
      step();
   endtask

   task automatic test_bad_grant();
      logic [3:0] gv [4];
      logic [7:0] e, a;
      gv[0] = 4'b1111; gv[1] = 4'b0110; gv[2] = 4'b1001; gv[3] = 4'b0011;
      for (int p = 0; p < 4; p++) begin
         grant_i = gv[p][3:2]; s_valid_i = gv[p][1:0];
         for (int c = 0; c < 3; c++) begin
            @(negedge clk); checks++;
            a = {2'b00, ctl, req_o}; e = {2'b00, 4'b0000, gv[p][1:0]};
            if (a !== e) begin errors++; $display("FAIL badgrant_p%0d: got %b expected %b", p, a, e); end
            step();
         end
      end
      grant_i = '0; s_valid_i = '0;
      @(negedge clk); checks++; expc = 4'b0000;
      if (ctl !== expc) begin errors++; $display("FAIL badgrant_end: got %b expected %b", ctl, expc); end
      step();
   endtask

   task automatic test_reset_midpacket();
      put(0, 8'h61, 1'b1, 1'b0); grant_i = 2'b01;
      step();
      @(negedge clk); checks++; expc = 4'b0001;
      if (ctl !== expc) begin errors++; $display("FAIL rstmid_rdy: got %b expected %b", ctl, expc); end
      step(); put(0, 8'h62, 1'b1, 1'b0); nrst = 1'b0;
      @(negedge clk); checks++; expv = {1'b1, 1'b0, 1'b0, 8'h61, 1'b0, 2'b01};
      if (obs !== expv) begin errors++; $display("FAIL rstmid_b0: got %b expected %b", obs, expv); end
      step(); nrst = 1'b1; put(0, 8'h63, 1'b1, 1'b1); grant_i = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); checks++; expv = '0;
         if (obs !== expv) begin errors++; $display("FAIL rstmid_clr%0d: got %b expected %b", c, obs, expv); end
         step();
      end
      put(0, 8'h00, 1'b0, 1'b0);
      step();
   endtask

   task automatic test_random();
      beat_t bt, acc_beat, hold_beat, got, want;
      logic [N-1:0] mask;
      bit acc_pend, stall_prev, arb_due, in_flight, done;
      int k, len;
      acc_pend = 0; stall_prev = 0; arb_due = 0; in_flight = 0; done = 0;
      hold_beat = '0; acc_beat = '0;
      for (int p = 0; p < 40; p++) begin
         k   = $urandom_range(0, N-1);
         len = $urandom_range(1, 5);
         for (int b = 0; b < len; b++) begin
            bt.id = IDW'(k); bt.data = W'($urandom); bt.last = (b == len - 1);
            sq[k].push_back(bt);
         end
      end
      pick_next(N-1);
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         for (int s = 0; s < N; s++) begin
            if (sq[s].size() > 0 && $urandom_range(0, 99) < 70) put(s, sq[s][0].data, 1'b1, sq[s][0].last);
            else put(s, W'($urandom), 1'b0, 1'($urandom));
         end
         m_ready_i = ($urandom_range(0, 99) < 75);
         grant_i   = in_flight ? N'($urandom) : (has_tgt ? (N'(1) << cur) : '0);
         @(negedge clk);
         got = {m_id_o, m_data_o, m_last_o};
         checks++;
         if (arb_en_o !== arb_due) begin errors++; $display("FAIL rnd_arb cyc %0d: got %b expected %b", cyc, arb_en_o, arb_due); end
         if (acc_pend) begin
            checks++;
            if (m_valid_o !== 1'b1 || got !== acc_beat) begin errors++; $display("FAIL rnd_latency cyc %0d: got v=%b %h expected v=1 %h", cyc, m_valid_o, got, acc_beat); end
         end else if (stall_prev) begin
            checks++;
            if (m_valid_o !== 1'b1 || got !== hold_beat) begin errors++; $display("FAIL rnd_hold cyc %0d: got v=%b %h expected v=1 %h", cyc, m_valid_o, got, hold_beat); end
         end
         if (m_valid_o && m_ready_i) begin
            checks++;
            if (expq.size() == 0) begin errors++; $display("FAIL rnd_extra cyc %0d: got beat %h expected none", cyc, got); end
            else begin
               want = expq.pop_front();
               if (got !== want) begin errors++; $display("FAIL rnd_order cyc %0d: got %h expected %h", cyc, got, want); end
            end
         end
         mask = has_tgt ? (N'(1) << cur) : '0;
         checks++;
         if ((s_ready_o & ~mask) !== '0 || req_o !== s_valid_i) begin
            errors++; $display("FAIL rnd_ready cyc %0d: got rdy=%b req=%b expected rdy within %b req=%b", cyc, s_ready_o, req_o, mask, s_valid_i);
         end
         stall_prev = m_valid_o && !m_ready_i;
         hold_beat  = got;
         acc_pend   = 0;
         arb_due    = 0;
         if (has_tgt && s_valid_i[cur] && s_ready_o[cur]) begin
            acc_beat = sq[cur].pop_front();
            acc_pend = 1;
            if (acc_beat.last) begin
               arb_due   = 1;
               in_flight = 0;
               pick_next(cur);
            end else begin
               in_flight = 1;
            end
         end
         done = !has_tgt && expq.size() == 0 && !acc_pend && !arb_due;
         step();
      end
      checks++;
      if (!done) begin errors++; $display("FAIL rnd_timeout: got %0d beats outstanding expected 0", expq.size()); end
      s_valid_i = '0; grant_i = '0; m_ready_i = 1'b1;
      step(); step();
   endtask

   initial begin
      nrst = 1'b0; s_data_i = '0; s_valid_i = '0; s_last_i = '0; grant_i = '0; m_ready_i = 1'b1;
      test_reset();
      test_basic();
      test_two_streams();
      test_backpressure();
      test_single_beat();
      test_bad_grant();
      test_reset_midpacket();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stream_packet_mux.md
Name: stream_packet_mux

Overview:
- Downstream consumer of the round-robin grant vector.
- Latches a one-hot grant, then forwards the granted input stream's beats to one registered output until the packet's last beat is accepted.
- Pulses the arbiter's advance enable at each packet end.
- Sits between the per-stream input FIFOs/QoS stage and the arbiter's single output port, so packets are never interleaved.

Parameters:
- STREAM_COUNT, 2, number of input streams; must match the arbiter.
- T_DATA_WIDTH, 8, data width per stream.
- T_ID_WIDTH, $clog2(STREAM_COUNT) (minimum 1), width of the stream index output.

Ports:
- clk  input  1  clock.
- nrst  input  1  reset, synchronous, active-low.
- s_data_i  input  STREAM_COUNT*T_DATA_WIDTH  packed input data; stream k occupies bits [k*T_DATA_WIDTH +: T_DATA_WIDTH].
- s_valid_i  input  STREAM_COUNT  per-stream valid.
- s_last_i  input  STREAM_COUNT  per-stream end-of-packet flag.
- s_ready_o  output  STREAM_COUNT  per-stream ready.
- req_o  output  STREAM_COUNT  request vector to arbiter; equals s_valid_i, combinational.
- grant_i  input  STREAM_COUNT  one-hot grant from arbiter; all-zero means no grant.
- arb_en_o  output  1  single-cycle pulse that advances the arbiter.
- m_data_o  output  T_DATA_WIDTH  output data, registered.
- m_id_o  output  T_ID_WIDTH  index of the source stream, registered.
- m_last_o  output  1  output end-of-packet flag, registered.
- m_valid_o  output  1  output valid, registered.
- m_ready_i  input  1  downstream ready.

Behaviour:
- Reset (nrst low at posedge clk): state=IDLE, sel_r=0, m_valid_o=0, m_data_o=0, m_id_o=0, m_last_o=0, arb_en_o=0. s_ready_o is 0 while in IDLE.
- Reset mid-packet abandons the packet: the output register is cleared and no arb_en_o pulse is issued.
- FSM states: IDLE, XFER, SETTLE.
- IDLE: each cycle evaluate g = grant_i & s_valid_i.
  - If g is nonzero and one-hot: sel_r<=grant_i, go to XFER.
  - If grant_i is all-zero, multi-hot, or points to a non-valid stream: stay in IDLE, no pulse.
- XFER:
  - s_ready_o = sel_r & {STREAM_COUNT{~m_valid_o | m_ready_i}}.
  - Accept condition: |(s_valid_i & s_ready_o).
  - On accept, load the output register with the selected stream's data and last, m_id_o = index of sel_r, m_valid_o<=1.
  - If m_valid_o && m_ready_i and no accept: m_valid_o<=0.
  - On an accepted beat with selected s_last=1: arb_en_o=1 in the following cycle (registered pulse, exactly one cycle), go to SETTLE.
- SETTLE:
  - Lasts exactly one cycle, which covers the arbiter's one-cycle registered enable.
  - s_ready_o is 0; the output register still drains on m_ready_i.
  - Then go to IDLE.
- Latency: a beat accepted at cycle N is visible on m_* at cycle N+1.
  - Throughput is one beat/cycle inside a packet when m_ready_i is held high.
  - Packet-to-packet gap on the input side is at least 2 cycles (SETTLE + IDLE capture).
- Backpressure: m_data_o, m_id_o and m_last_o hold stable while m_valid_o=1 and m_ready_i=0.
- Single-beat packet (last on first beat) is legal: XFER lasts one accept cycle.
- Valid drops mid-packet on the selected stream: stay in XFER and wait. There is no timeout and the grant is not re-evaluated.
- Valid or last on non-selected streams is ignored; their s_ready_o=0.
- grant_i changing during XFER or SETTLE is ignored; only IDLE samples it.
- Simultaneous events:
  - The final-beat accept and the output drain in the same cycle: the register loads the new beat and m_valid_o stays 1.
  - The arb_en_o pulse is independent of downstream drain.
- m_id_o encoding: binary index of the set bit of sel_r, LSB stream = 0.

Test Plan:
- Reset, then stream 0 sends a 3-beat packet (0x11,0x22,0x33 last) with grant_i=01 and m_ready_i=1:
  - m_* shows the three beats on consecutive cycles with m_id_o=0 and m_last_o on 0x33.
  - arb_en_o pulses exactly once, one cycle after 0x33 is accepted.
- Both streams valid; grant_i=10 then 01 after the pulse:
  - Stream 1's full packet appears before any stream 0 beat; no interleaving.
  - m_id_o sequence is 1,1,…,0,0.
- m_ready_i=0 for 4 cycles in mid-packet:
  - m_data_o is held, the selected s_ready_o=0, m_valid_o stays 1.
  - After release, the remaining beats complete with no loss or duplication.
- Single-beat packet 0xA5 on stream 1 (last=1): one output beat with m_last_o=1; arb_en_o pulses once; FSM returns to IDLE after SETTLE.
- grant_i=11 (multi-hot) or grant_i=01 while only stream 1 is valid: no capture, s_ready_o=00, no arb_en_o pulse.
- nrst low during the second beat of a packet: next cycle m_valid_o=0, s_ready_o=00, state=IDLE, no arb_en_o pulse.
